// File: rtl/aclk_pkg.sv
// ============================================================================
// Module      : aclk_pkg
// Description : Shared constants and helpers for the multi-slot alarm block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aclk_pkg;

   localparam int c_DIGIT_W = 4;

   localparam logic [1:0] c_IDLE    = 2'b00;
   localparam logic [1:0] c_RINGING = 2'b01;
   localparam logic [1:0] c_SNOOZE  = 2'b10;

   // Lowest set bit of a match vector; returns 0 for an empty vector.
   function automatic logic [2:0] lowest_idx(input logic [7:0] vec);
      lowest_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (vec[i]) lowest_idx = 3'(i);
      end
   endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_slot.sv
// ============================================================================
// Module      : alarm_slot
// Description : One alarm slot: BCD time store, enable bit and equality hit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_slot
   import aclk_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_time,
   input  logic                     wr_en,
   input  logic                     en_val,
   input  logic [4*c_DIGIT_W-1:0]   new_time,
   input  logic [4*c_DIGIT_W-1:0]   cur_time,
   output logic [4*c_DIGIT_W-1:0]   slot_time,
   output logic                     hit
);

   logic [4*c_DIGIT_W-1:0] r_time;
   logic                   r_en;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_time <= '0;
         r_en   <= 1'b0;
      end else begin
         if (wr_time) r_time <= new_time;
         if (wr_en)   r_en   <= en_val;
      end
   end

   assign slot_time = r_time;
   assign hit       = r_en && (r_time == cur_time);

endmodule

`default_nettype wire

// File: rtl/multi_alarm_ctrl.sv
// ============================================================================
// Module      : multi_alarm_ctrl
// Description : NUM_ALARMS-slot BCD alarm with ring/snooze/timeout control.
//               Define ALARM_PULSE_EN for a 1 s on / 1 s off beep while ringing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_alarm_ctrl
   import aclk_pkg::*;
#(
   parameter int NUM_ALARMS  = 4,
   parameter int IDX_W       = 2,
   parameter int SNOOZE_MIN  = 5,
   parameter int MAX_SNOOZE  = 3,
   parameter int TIMEOUT_SEC = 60
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             one_second,
   input  logic             one_minute,
   input  logic [3:0]       cur_ms_hr,
   input  logic [3:0]       cur_ls_hr,
   input  logic [3:0]       cur_ms_min,
   input  logic [3:0]       cur_ls_min,
   input  logic [3:0]       new_ms_hr,
   input  logic [3:0]       new_ls_hr,
   input  logic [3:0]       new_ms_min,
   input  logic [3:0]       new_ls_min,
   input  logic             load_alarm,
   input  logic [IDX_W-1:0] alarm_sel,
   input  logic             en_wr,
   input  logic             en_val,
   input  logic             snooze_button,
   input  logic             stop_button,
   output logic [3:0]       rd_ms_hr,
   output logic [3:0]       rd_ls_hr,
   output logic [3:0]       rd_ms_min,
   output logic [3:0]       rd_ls_min,
   output logic             alarm_sound,
   output logic [IDX_W-1:0] active_idx,
   output logic             ringing,
   output logic             snoozing
);

   localparam int c_TW = 4 * c_DIGIT_W;

   logic [c_TW-1:0]       w_cur, w_new, w_rd, r_prev_time;
   logic [c_TW-1:0]       w_slot_time [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] w_hit, w_match, w_other, w_act_mask;
   logic                  w_time_chg;
   logic [IDX_W-1:0]      w_win_idx, w_other_idx;
   logic                  r_snz_d1, r_snz_d2, r_stp_d1, r_stp_d2;
   logic                  w_stop_p, w_snz_p, w_disable_act;

   logic [1:0]            r_state, w_state_nxt;
   logic [IDX_W-1:0]      r_active_idx, w_active_nxt;
   logic [7:0]            r_sec_cnt, w_sec_nxt;
   logic [3:0]            r_min_cnt, w_min_nxt;
   logic [3:0]            r_snz_cnt, w_snz_cnt_nxt;
   logic                  r_ringing, r_snoozing, r_sound;
   logic                  w_ringing_d, w_snoozing_d, w_sound_d;

   assign w_cur = {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min};
   assign w_new = {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min};

   generate
      for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
         alarm_slot u_slot (
            .clock     (clock),
            .reset     (reset),
            .wr_time   (load_alarm && (alarm_sel == IDX_W'(gi))),
            .wr_en     (en_wr && (alarm_sel == IDX_W'(gi))),
            .en_val    (en_val),
            .new_time  (w_new),
            .cur_time  (w_cur),
            .slot_time (w_slot_time[gi]),
            .hit       (w_hit[gi])
         );
      end
   endgenerate

   // Out-of-range selects fall through to the zero default.
   always_comb begin
      w_rd = '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         if (alarm_sel == IDX_W'(i)) w_rd = w_slot_time[i];
      end
   end

   assign {rd_ms_hr, rd_ls_hr, rd_ms_min, rd_ls_min} = w_rd;

   // A match only fires on the cycle the time value moves.
   assign w_time_chg  = (w_cur != r_prev_time);
   assign w_match     = w_hit & {NUM_ALARMS{w_time_chg}};
   assign w_act_mask  = NUM_ALARMS'(1) << r_active_idx;
   assign w_other     = w_match & ~w_act_mask;
   assign w_win_idx   = IDX_W'(lowest_idx(8'(w_match)));
   assign w_other_idx = IDX_W'(lowest_idx(8'(w_other)));

   assign w_stop_p      = r_stp_d1 && !r_stp_d2;
   assign w_snz_p       = r_snz_d1 && !r_snz_d2 && !w_stop_p;
   assign w_disable_act = en_wr && !en_val && (alarm_sel == r_active_idx);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_prev_time  <= '0;
         r_snz_d1     <= 1'b0;
         r_snz_d2     <= 1'b0;
         r_stp_d1     <= 1'b0;
         r_stp_d2     <= 1'b0;
         r_state      <= c_IDLE;
         r_active_idx <= '0;
         r_sec_cnt    <= '0;
         r_min_cnt    <= '0;
         r_snz_cnt    <= '0;
         r_ringing    <= 1'b0;
         r_snoozing   <= 1'b0;
         r_sound      <= 1'b0;
      end else begin
         r_prev_time  <= w_cur;
         r_snz_d1     <= snooze_button;
         r_snz_d2     <= r_snz_d1;
         r_stp_d1     <= stop_button;
         r_stp_d2     <= r_stp_d1;
         r_state      <= w_state_nxt;
         r_active_idx <= w_active_nxt;
         r_sec_cnt    <= w_sec_nxt;
         r_min_cnt    <= w_min_nxt;
         r_snz_cnt    <= w_snz_cnt_nxt;
         r_ringing    <= w_ringing_d;
         r_snoozing   <= w_snoozing_d;
         r_sound      <= w_sound_d;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_active_nxt  = r_active_idx;
      w_sec_nxt     = r_sec_cnt;
      w_min_nxt     = r_min_cnt;
      w_snz_cnt_nxt = r_snz_cnt;
      case (r_state)
         c_IDLE: begin
            if (|w_match) begin
               w_state_nxt   = c_RINGING;
               w_active_nxt  = w_win_idx;
               w_sec_nxt     = '0;
               w_snz_cnt_nxt = '0;
            end
         end
         c_RINGING: begin
            if (w_stop_p || w_disable_act) begin
               w_state_nxt = c_IDLE;
            end else if (w_snz_p && (r_snz_cnt < 4'(MAX_SNOOZE))) begin
               w_state_nxt   = c_SNOOZE;
               w_min_nxt     = 4'(SNOOZE_MIN);
               w_snz_cnt_nxt = r_snz_cnt + 4'd1;
            end else if (one_second) begin
               w_sec_nxt = r_sec_cnt + 8'd1;
               if (r_sec_cnt == 8'(TIMEOUT_SEC - 1)) w_state_nxt = c_IDLE;
            end
         end
         c_SNOOZE: begin
            if (w_stop_p || w_disable_act) begin
               w_state_nxt = c_IDLE;
            end else if (|w_other) begin
               w_state_nxt   = c_RINGING;
               w_active_nxt  = w_other_idx;
               w_sec_nxt     = '0;
               w_snz_cnt_nxt = '0;
            end else if (one_minute) begin
               w_min_nxt = r_min_cnt - 4'd1;
               if (r_min_cnt == 4'd1) begin
                  w_state_nxt = c_RINGING;
                  w_sec_nxt   = '0;
               end
            end
         end
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Outputs are computed from the next state so they land in registers.
   always_comb begin
      w_ringing_d  = (w_state_nxt == c_RINGING);
      w_snoozing_d = (w_state_nxt == c_SNOOZE);
`ifdef ALARM_PULSE_EN
      if (w_state_nxt != c_RINGING)  w_sound_d = 1'b0;
      else if (r_state != c_RINGING) w_sound_d = 1'b1;
      else if (one_second)           w_sound_d = !r_sound;
      else                           w_sound_d = r_sound;
`else
      w_sound_d = (w_state_nxt == c_RINGING);
`endif
   end

   assign ringing     = r_ringing;
   assign snoozing    = r_snoozing;
   assign alarm_sound = r_sound;
   assign active_idx  = r_active_idx;

endmodule

`default_nettype wire

// File: tb/tb_multi_alarm_ctrl.sv
// ============================================================================
// Module      : tb_multi_alarm_ctrl
// Description : Self-checking bench for multi_alarm_ctrl (vectors, directed
//               sequences and randomized traffic against a reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_alarm_ctrl;

   localparam int NA   = 4;
   localparam int IW   = 2;
   localparam int SNZ  = 5;
   localparam int MAXS = 3;
   localparam int TO   = 60;
`ifdef ALARM_PULSE_EN
   localparam bit PULSE = 1'b1;
`else
   localparam bit PULSE = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          one_second, one_minute;
   logic [3:0]    cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min;
   logic [3:0]    new_ms_hr, new_ls_hr, new_ms_min, new_ls_min;
   logic          load_alarm, en_wr, en_val, snooze_button, stop_button;
   logic [IW-1:0] alarm_sel;
   logic [3:0]    rd_ms_hr, rd_ls_hr, rd_ms_min, rd_ls_min;
   logic          alarm_sound, ringing, snoozing;
   logic [IW-1:0] active_idx;

   always #5 clock = ~clock;

   multi_alarm_ctrl #(
      .NUM_ALARMS(NA), .IDX_W(IW), .SNOOZE_MIN(SNZ),
      .MAX_SNOOZE(MAXS), .TIMEOUT_SEC(TO)
   ) dut (
      .clock(clock), .reset(reset), .one_second(one_second), .one_minute(one_minute),
      .cur_ms_hr(cur_ms_hr), .cur_ls_hr(cur_ls_hr), .cur_ms_min(cur_ms_min), .cur_ls_min(cur_ls_min),
      .new_ms_hr(new_ms_hr), .new_ls_hr(new_ls_hr), .new_ms_min(new_ms_min), .new_ls_min(new_ls_min),
      .load_alarm(load_alarm), .alarm_sel(alarm_sel), .en_wr(en_wr), .en_val(en_val),
      .snooze_button(snooze_button), .stop_button(stop_button),
      .rd_ms_hr(rd_ms_hr), .rd_ls_hr(rd_ls_hr), .rd_ms_min(rd_ms_min), .rd_ls_min(rd_ls_min),
      .alarm_sound(alarm_sound), .active_idx(active_idx), .ringing(ringing), .snoozing(snoozing)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Counts remaining seconds/minutes/snoozes down rather than up.
   logic [15:0] m_slot [NA];
   bit          m_en [NA];
   logic [15:0] m_prev;
   bit          m_stp_h [2];
   bit          m_snz_h [2];
   int          m_mode;          // 0 quiet, 1 ringing, 2 snoozing
   int          m_active, m_secs_left, m_mins_left, m_snoozes_left;
   bit          m_beep;

   task automatic model_reset();
      for (int i = 0; i < NA; i++) begin m_slot[i] = '0; m_en[i] = 0; end
      m_prev = '0; m_stp_h = '{0, 0}; m_snz_h = '{0, 0};
      m_mode = 0; m_active = 0; m_secs_left = 0; m_mins_left = 0; m_snoozes_left = 0; m_beep = 0;
   endtask

   task automatic model_edge();
      logic [15:0] t;
      int first, other;
      bit stop_p, snz_p, dis;
      t = {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min};
      first = -1; other = -1;
      for (int i = 0; i < NA; i++) begin
         if (m_en[i] && m_slot[i] == t && t != m_prev) begin
            if (first < 0) first = i;
            if (i != m_active && other < 0) other = i;
         end
      end
      stop_p = m_stp_h[0] && !m_stp_h[1];
      snz_p  = m_snz_h[0] && !m_snz_h[1] && !stop_p;
      dis    = en_wr && !en_val && (int'(alarm_sel) == m_active);
      if (m_mode == 0) begin
         if (first >= 0) begin
            m_mode = 1; m_active = first; m_secs_left = TO; m_snoozes_left = MAXS; m_beep = 1;
         end
      end else if (m_mode == 1) begin
         if (stop_p || dis) m_mode = 0;
         else if (snz_p && m_snoozes_left > 0) begin
            m_mode = 2; m_mins_left = SNZ; m_snoozes_left--;
         end else if (one_second) begin
            m_secs_left--; m_beep = !m_beep;
            if (m_secs_left == 0) m_mode = 0;
         end
      end else begin
         if (stop_p || dis) m_mode = 0;
         else if (other >= 0) begin
            m_mode = 1; m_active = other; m_secs_left = TO; m_snoozes_left = MAXS; m_beep = 1;
         end else if (one_minute) begin
            m_mins_left--;
            if (m_mins_left == 0) begin m_mode = 1; m_secs_left = TO; m_beep = 1; end
         end
      end
      if (load_alarm) m_slot[alarm_sel] = {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min};
      if (en_wr) m_en[alarm_sel] = en_val;
      m_prev = t;
      m_stp_h[1] = m_stp_h[0]; m_stp_h[0] = stop_button;
      m_snz_h[1] = m_snz_h[0]; m_snz_h[0] = snooze_button;
   endtask

   function automatic logic [31:0] model_pack();
      bit snd;
      snd = (m_mode == 1) ? (PULSE ? m_beep : 1'b1) : 1'b0;
      return {11'd0, m_mode == 1, m_mode == 2, snd, 2'(m_active), m_slot[alarm_sel]};
   endfunction

   function automatic logic [31:0] dut_pack();
      return {11'd0, ringing, snoozing, alarm_sound, active_idx,
              rd_ms_hr, rd_ls_hr, rd_ms_min, rd_ls_min};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic set_cur(input logic [15:0] t);
      {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min} = t;
   endtask

   task automatic set_new(input logic [15:0] t);
      {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min} = t;
   endtask

   task automatic quiet();
      load_alarm = 0; en_wr = 0; en_val = 0; snooze_button = 0; stop_button = 0;
      one_second = 0; one_minute = 0;
   endtask

   task automatic step(input string name);
      @(posedge clock);
      model_edge();
      @(negedge clock);
      chk(name, dut_pack(), model_pack());
   endtask

   task automatic press_snooze();
      snooze_button = 1; step("snz_hold");
      snooze_button = 0; step("snz_rel");
   endtask

   task automatic press_stop();
      stop_button = 1; step("stop_hold");
      stop_button = 0; step("stop_rel");
   endtask

   task automatic minute_tick();
      one_minute = 1; step("min_tick");
      one_minute = 0;
   endtask

   task automatic second_tick();
      one_second = 1; step("sec_tick");
      one_second = 0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [15:0] cur;
      logic        ld;
      logic [1:0]  sel;
      logic [15:0] nw;
      logic        ew, ev, sz, st;
      logic        e_ring, e_snz, e_snd;
      logic [1:0]  e_act;
      logic [15:0] e_rd;
   } vec_t;

   vec_t tbl [14];
   logic [15:0] times [5];

   initial begin
      tbl[0]  = '{16'h0729, 1, 2'd1, 16'h0730, 1, 1, 0, 0, 0, 0, 0, 2'd0, 16'h0730};
      tbl[1]  = '{16'h0729, 0, 2'd1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0730};
      tbl[2]  = '{16'h0730, 0, 2'd1, 16'h0000, 0, 0, 0, 0, 1, 0, 1, 2'd1, 16'h0730};
      tbl[3]  = '{16'h0730, 0, 2'd1, 16'h0000, 0, 0, 0, 0, 1, 0, 1, 2'd1, 16'h0730};
      tbl[4]  = '{16'h0730, 0, 2'd1, 16'h0000, 0, 0, 0, 1, 1, 0, 1, 2'd1, 16'h0730};
      tbl[5]  = '{16'h0730, 0, 2'd1, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 2'd1, 16'h0730};
      tbl[6]  = '{16'h0730, 0, 2'd1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 2'd1, 16'h0730};
      tbl[7]  = '{16'h0730, 1, 2'd0, 16'h0600, 1, 1, 0, 0, 0, 0, 0, 2'd1, 16'h0600};
      tbl[8]  = '{16'h0730, 1, 2'd2, 16'h0600, 1, 1, 0, 0, 0, 0, 0, 2'd1, 16'h0600};
      tbl[9]  = '{16'h0559, 0, 2'd0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 2'd1, 16'h0600};
      tbl[10] = '{16'h0600, 0, 2'd0, 16'h0000, 0, 0, 0, 0, 1, 0, 1, 2'd0, 16'h0600};
      tbl[11] = '{16'h0600, 0, 2'd0, 16'h0000, 0, 0, 0, 1, 1, 0, 1, 2'd0, 16'h0600};
      tbl[12] = '{16'h0600, 0, 2'd0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0600};
      tbl[13] = '{16'h0600, 0, 2'd0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0600};
      times = '{16'h0000, 16'h0600, 16'h0730, 16'h0800, 16'h0801};

      quiet(); alarm_sel = '0; set_cur(16'h0000); set_new(16'h0000);
      reset = 0;
      repeat (2) @(negedge clock);
      model_reset();
      chk("reset_outputs", dut_pack(), 32'd0);
      reset = 1;

      // single-slot ring/stop, then lowest-index priority
      foreach (tbl[i]) begin
         set_cur(tbl[i].cur); load_alarm = tbl[i].ld; alarm_sel = tbl[i].sel;
         set_new(tbl[i].nw); en_wr = tbl[i].ew; en_val = tbl[i].ev;
         snooze_button = tbl[i].sz; stop_button = tbl[i].st;
         step("tbl_model");
         chk($sformatf("tbl_row%0d", i),
             {ringing, snoozing, alarm_sound, active_idx, rd_ms_hr, rd_ls_hr, rd_ms_min, rd_ls_min},
             {tbl[i].e_ring, tbl[i].e_snz, tbl[i].e_snd, tbl[i].e_act, tbl[i].e_rd});
      end
      quiet();

      // snooze cycles, limit on snoozes
      set_cur(16'h0730); step("snz_trigger");
      chk("snz_trigger_ring", {ringing, active_idx}, {1'b1, 2'd1});
      for (int r = 0; r < MAXS; r++) begin
         press_snooze();
         chk("snz_entered", {ringing, snoozing, alarm_sound}, 3'b010);
         repeat (SNZ - 1) minute_tick();
         chk("snz_still", snoozing, 1'b1);
         minute_tick();
         chk("snz_reringing", {ringing, snoozing, alarm_sound}, 3'b101);
      end
      press_snooze();
      chk("snz_limit_ignored", {ringing, snoozing}, 2'b10);
      press_stop();
      chk("snz_stop", {ringing, alarm_sound}, 2'b00);

      // unattended timeout, static time does not re-trigger
      set_cur(16'h0731); step("to_away");
      set_cur(16'h0730); step("to_trigger");
      one_second = 1;
      repeat (TO - 1) step("to_count");
      chk("to_before_last", ringing, 1'b1);
      step("to_last");
      one_second = 0;
      chk("to_expired", {ringing, alarm_sound}, 2'b00);
      repeat (5) step("to_static");
      chk("to_no_refire", ringing, 1'b0);

      // different-slot match while snoozing, stop beats snooze
      alarm_sel = 2'd3; set_new(16'h0800); load_alarm = 1; en_wr = 1; en_val = 1;
      step("s5_load3"); quiet();
      set_cur(16'h0600); step("s5_trigger0");
      chk("s5_ring0", {ringing, active_idx}, {1'b1, 2'd0});
      press_snooze();
      set_cur(16'h0800); step("s5_match3");
      chk("s5_ring3", {ringing, snoozing, active_idx}, {2'b10, 2'd3});
      snooze_button = 1; stop_button = 1; step("s5_both_hold");
      snooze_button = 0; stop_button = 0; step("s5_both_rel");
      chk("s5_stop_wins", {ringing, snoozing}, 2'b00);

      // same-slot match while snoozing is ignored; disabling active slot stops
      alarm_sel = 2'd2; en_wr = 1; en_val = 0; step("s5_dis2"); quiet();
      set_cur(16'h0601); step("s5_away");
      set_cur(16'h0600); step("s5_trig0b");
      press_snooze();
      set_cur(16'h0601); step("s5_away2");
      set_cur(16'h0600); step("s5_same");
      chk("s5_same_ignored", {ringing, snoozing, active_idx}, {2'b01, 2'd0});
      alarm_sel = 2'd0; en_wr = 1; en_val = 0; step("s5_dis_active"); quiet();
      chk("s5_dis_idle", {ringing, snoozing}, 2'b00);

      // beep pattern and asynchronous reset mid-ring
      set_cur(16'h0730); step("p_trigger");
      chk("p_entry", {ringing, alarm_sound}, 2'b11);
      for (int k = 1; k <= 3; k++) begin
         second_tick();
         chk($sformatf("p_tick%0d", k), alarm_sound, PULSE ? 1'((k + 1) % 2) : 1'b1);
      end
      #2 reset = 0;
      #1 chk("async_reset", dut_pack(), 32'd0);
      model_reset();
      @(posedge clock); @(negedge clock);
      reset = 1;
      set_cur(16'h0001); step("rst_away");
      set_cur(16'h0000); step("rst_zero");
      chk("rst_enables_cleared", ringing, 1'b0);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(99) < 20) set_cur(times[$urandom_range(4)]);
         load_alarm = ($urandom_range(99) < 6);
         set_new(times[$urandom_range(4)]);
         alarm_sel = 2'($urandom_range(NA - 1));
         en_wr  = ($urandom_range(99) < 8);
         en_val = ($urandom_range(99) < 70);
         if ($urandom_range(99) < 10) snooze_button = !snooze_button;
         if ($urandom_range(99) < 4)  stop_button   = !stop_button;
         one_second = ($urandom_range(99) < 25);
         one_minute = ($urandom_range(99) < 15);
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/multi_alarm_ctrl.md
Name: multi_alarm_ctrl

Overview:
Parametrised successor to the single-alarm path. Holds NUM_ALARMS BCD alarm slots, each with its own enable. Compares every enabled slot against the running BCD time from the counter and drives alarm_sound through a ring/snooze/timeout FSM. Sits between the counter/keyreg outputs and the LCD driver, replacing the single alarm register and sound compare.

Parameters:
NUM_ALARMS, 4, number of alarm slots (2..8)
IDX_W, 2, width of slot index; must be >= clog2(NUM_ALARMS)
SNOOZE_MIN, 5, snooze length in one_minute ticks (1..15)
MAX_SNOOZE, 3, snoozes allowed per ring event; further snooze presses are ignored
TIMEOUT_SEC, 60, one_second ticks of unattended ringing before auto-stop (1..255)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
one_second  in  1  1-cycle tick from timegen
one_minute  in  1  1-cycle tick from timegen
cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min  in  4 each  current BCD time
new_ms_hr, new_ls_hr, new_ms_min, new_ls_min  in  4 each  key buffer digits
load_alarm  in  1  write new_* into slot alarm_sel
alarm_sel  in  IDX_W  slot for load, enable write and readback
en_wr  in  1  write en_val to enable bit of slot alarm_sel
en_val  in  1  enable value
snooze_button  in  1  level, edge-detected internally
stop_button  in  1  level, edge-detected internally
rd_ms_hr, rd_ls_hr, rd_ms_min, rd_ls_min  out  4 each  stored time of slot alarm_sel (combinational read)
alarm_sound  out  1  sounder drive
active_idx  out  IDX_W  slot currently ringing or snoozed
ringing  out  1  FSM in RINGING
snoozing  out  1  FSM in SNOOZE

Behaviour:
- Reset (reset=0, async): all slots 0000 (00:00); all enables 0; FSM IDLE; all counters 0; button edge registers 0; alarm_sound, ringing, snoozing = 0; active_idx = 0.
- Slot write: load_alarm updates slot alarm_sel at the clock edge. en_wr updates its enable bit. Both may occur in the same cycle. alarm_sel >= NUM_ALARMS: write ignored, readback 0.
- Match event: a register holds the previous cur_* value. A match fires in the cycle where cur_* differs from that register and equals an enabled slot. Covers both a one_minute increment and a load_new_c time set. Time held static never re-fires. Lowest matching index wins.
- Button press: rising edge of the registered button (1-cycle latency). If stop and snooze are pressed in the same cycle, stop wins.
- FSM IDLE: on a match, go to RINGING. Set active_idx to the winning slot, clear snooze_cnt and sec_cnt.
- FSM RINGING, alarm_sound = 1:
  - stop: go to IDLE.
  - snooze with snooze_cnt < MAX_SNOOZE: go to SNOOZE, load min_cnt = SNOOZE_MIN, increment snooze_cnt.
  - snooze at MAX_SNOOZE: ignored.
  - sec_cnt increments on each one_second. When it reaches TIMEOUT_SEC, go to IDLE.
  - New matches are ignored.
- FSM SNOOZE, alarm_sound = 0:
  - min_cnt decrements on one_minute. When it reaches 0, go to RINGING with sec_cnt = 0.
  - stop: go to IDLE.
  - A match on a different slot goes to RINGING with the new active_idx and clears snooze_cnt. A match on the same slot is ignored.
- Disabling the active slot (en_wr, en_val=0, alarm_sel=active_idx) in RINGING or SNOOZE: go to IDLE on the next edge.
- Reloading the active slot's time does not change FSM state.
- Outputs ringing, snoozing and alarm_sound are registered; they update one cycle after the causing event.
- Counter widths: sec_cnt 8 bit, min_cnt 4 bit, snooze_cnt 4 bit. No wrap is reachable, because each counter saturates at its terminal value.

Optional Feature:
ALARM_PULSE_EN
- Defined: in RINGING, alarm_sound toggles on each one_second tick, producing a 1 s on / 1 s off beep. It starts at 1 on RINGING entry.
- Undefined: alarm_sound is a continuous 1 throughout RINGING.
- All other behaviour is identical in both builds.

Decomposition:
- Package aclk_pkg holds:
  - the FSM state encoding (IDLE=2'b00, RINGING=2'b01, SNOOZE=2'b10);
  - BCD digit width 4;
  - a function returning the lowest set index of a match vector.
- One sub-module, alarm_slot: one slot's time and enable storage plus its equality compare, instantiated NUM_ALARMS times via generate.

Test Plan:
1. Reset, slot1=07:30 enabled, time steps 07:29 -> 07:30 -> ringing=1, active_idx=1, alarm_sound=1 one cycle later. Stop press -> IDLE, sound 0.
2. Slots 0 and 2 both 06:00 and enabled, time reaches 06:00 -> active_idx=0.
3. Ringing, snooze pressed, then 5 one_minute ticks -> snoozing for 5 min, then ringing again. Fourth snooze press ignored (MAX_SNOOZE=3).
4. Ringing with no button and 60 one_second ticks -> IDLE on the 60th tick. Time held at the alarm value does not re-trigger.
5. Snoozing on slot 0, slot 3 matches -> RINGING, active_idx=3, snooze_cnt cleared. Same-cycle stop and snooze -> IDLE.
6. Async reset asserted mid-RINGING -> all outputs 0 immediately, enables cleared. With ALARM_PULSE_EN, alarm_sound alternates 1,0,1 across one_second ticks.
